cmp_uint_serial: RTL and testbench
==================================

CMP_UINT_SERIAL -- requirements
Module: cmp_uint_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits compared per cycle; WIDTH % DIGIT == 0 required; violation is an elaboration error.
REQ-003 The block SHALL have parameter IMPL_TYPE, default 0: digit-compare implementation selector passed to the sub-module; 0 = subtract-borrow form, 1 = magnitude-compare form; both give identical results.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with these ports: clk  input  1  clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  A/B/mode offered.
REQ-007 in_ready  output  1  block accepts an operation.
REQ-008 A  input  WIDTH  operand A.
REQ-009 B  input  WIDTH  operand B.
REQ-010 mode  input  2  00 LT, 01 LE, 10 GT, 11 GE.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 Y  output  1  comparison result per mode.
REQ-014 EQ  output  1  A == B.

Function
REQ-015 The block SHALL use states IDLE, RUN and DONE, with N = WIDTH/DIGIT.
REQ-016 Accept occurs on a rising edge with in_valid & in_ready: A, B and mode are registered, digit index is cleared, lt_acc=0, eq_acc=1, and the state goes to RUN.
REQ-017 in_ready SHALL be 1 in IDLE, 0 in RUN, and equal to out_ready in DONE.
REQ-018 In RUN, each cycle SHALL process digit i (bits i*DIGIT+DIGIT-1 : i*DIGIT), LSB digit first: lt_acc <= (dA<dB) | ((dA==dB) & lt_acc); eq_acc <= eq_acc & (dA==dB).
REQ-019 After digit N-1 the state SHALL go to DONE; out_valid rises exactly N edges after the accept edge (8 for the defaults).
REQ-020 In DONE, Y SHALL be: LT = lt_acc; LE = lt_acc|eq_acc; GT = ~lt_acc&~eq_acc; GE = ~lt_acc.
REQ-021 In DONE, EQ = eq_acc, and Y and EQ SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 In IDLE and RUN, out_valid, Y and EQ SHALL all be 0.
REQ-023 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-024 DONE with out_ready=1 and in_valid=1 SHALL accept the new operation on the same edge and go to RUN, giving back-to-back throughput of one result per N+1 cycles.
REQ-025 During RUN, input changes and in_valid SHALL be ignored; the registered operands are used.
REQ-026 N=1 (DIGIT=WIDTH) SHALL be legal: a single RUN cycle.
REQ-027 The block SHALL contain no wide carry chain; the longest combinational path is one DIGIT-bit compare plus the accumulator update.

Reset
REQ-028 When rst_n=0, the block SHALL asynchronously enter IDLE: in_ready=1 after reset; out_valid, Y, EQ, lt_acc and the digit index at 0; eq_acc at 1.
REQ-029 Reset asserted during RUN or DONE SHALL abandon the operation; no result is emitted after reset release.
REQ-030 Deassertion of rst_n SHALL take effect at a clock edge; the first accept is possible on the first edge after release.

Configuration
REQ-031 Macro CMP_SERIAL_SIGNED_EN compiles in the signed-comparison feature.
REQ-032 When CMP_SERIAL_SIGNED_EN is defined, the block SHALL have an extra input is_signed (1 bit), registered at accept.
REQ-033 With is_signed=1, the MSB of the final digit of A and B SHALL be inverted before compare, giving two's-complement ordering.
REQ-034 When CMP_SERIAL_SIGNED_EN is undefined, the port SHALL be absent and the comparison unsigned only.

Structure
REQ-035 Package cmp_serial_pkg SHALL hold the mode enum (CMP_LT/LE/GT/GE), the state enum (IDLE/RUN/DONE) and the IMPL_TYPE constants.
REQ-036 Sub-module cmp_digit (parameters DIGIT and IMPL_TYPE; inputs dA, dB, lt_in, eq_in; outputs lt_out, eq_out) SHALL be combinational and instantiated once.
REQ-037 The digit index counter SHALL be $clog2(N) bits wide, minimum 1.

Verification
REQ-038 Defaults, A=5, B=7, mode=LT -> out_valid 8 edges after accept, Y=1, EQ=0.
REQ-039 A=B=0xDEADBEEF, all four modes -> Y = 0,1,0,1 respectively, EQ=1.
REQ-040 A=0x80000000, B=0x7FFFFFFF, mode GT -> Y=1; with CMP_SERIAL_SIGNED_EN and is_signed=1 -> Y=0.
REQ-041 out_ready held 0 for 5 cycles in DONE -> Y/EQ/out_valid stable, in_ready=0; then out_ready=1 with in_valid=1 -> new accept on the same edge, next result after 8 more edges.
REQ-042 rst_n pulsed low at RUN cycle 3 -> immediate IDLE, out_valid never asserts for that operation; a fresh op afterwards gives the correct result.
REQ-043 Sweep DIGIT in {1,4,32}, 1000 random A/B/mode each -> Y/EQ match the reference comparison and latency equals WIDTH/DIGIT.

Source files
------------

// File: rtl/cmp_serial_pkg.sv
// cmp_serial_pkg: compare-mode and FSM-state enums plus the IMPL_TYPE selector values shared by cmp_uint_serial and cmp_digit
package cmp_serial_pkg;
  typedef enum logic [1:0] {CMP_LT, CMP_LE, CMP_GT, CMP_GE} cmp_mode_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int IMPL_SUB = 0;
  localparam int IMPL_MAG = 1;
endpackage

// File: rtl/cmp_digit.sv
// cmp_digit: combinational one-digit compare folded into running lt/eq accumulators (in: dA, dB, lt_in, eq_in; out: lt_out, eq_out)
module cmp_digit
  import cmp_serial_pkg::*;
#(
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = IMPL_SUB
) (
  input  logic [DIGIT-1:0] dA,
  input  logic [DIGIT-1:0] dB,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic             lt_out,
  output logic             eq_out
);
  logic d_lt, d_eq;
  if (IMPL_TYPE != IMPL_SUB && IMPL_TYPE != IMPL_MAG) begin : g_bad
    $error("cmp_digit: IMPL_TYPE must be 0 or 1");
  end
  if (IMPL_TYPE == IMPL_MAG) begin : g_mag
    assign d_lt = dA < dB;
    assign d_eq = dA == dB;
  end else begin : g_sub
    logic [DIGIT:0] diff;
    assign diff = {1'b0, dA} - {1'b0, dB};
    assign d_lt = diff[DIGIT];
    assign d_eq = diff[DIGIT-1:0] == '0;
  end
  assign lt_out = d_lt | (d_eq & lt_in);
  assign eq_out = eq_in & d_eq;
endmodule

// File: rtl/cmp_uint_serial.sv
// cmp_uint_serial: digit-serial A/B compare, LSB digit first (in: clk, rst_n, in_valid, A, B, mode, out_ready; out: in_ready, out_valid, Y, EQ; CMP_SERIAL_SIGNED_EN adds is_signed)
module cmp_uint_serial
  import cmp_serial_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = IMPL_SUB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       mode,
`ifdef CMP_SERIAL_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic             EQ
);
  localparam int N  = WIDTH / DIGIT;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  if (WIDTH % DIGIT != 0) begin : g_bad
    $error("cmp_uint_serial: WIDTH must be a multiple of DIGIT");
  end
  state_e           state_q, state_d;
  cmp_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             lt_q, lt_d, eq_q, eq_d;
  logic [DIGIT-1:0] da, db;
  logic             lt_nx, eq_nx, last, accept, y_sel;
`ifdef CMP_SERIAL_SIGNED_EN
  localparam logic [DIGIT-1:0] MSB = DIGIT'(1) << (DIGIT - 1);
  logic sgn_q, sgn_d;
`endif
  assign last     = idx_q == IW'(N - 1);
  assign in_ready = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  always_comb begin
    da = a_q[idx_q * DIGIT +: DIGIT];
    db = b_q[idx_q * DIGIT +: DIGIT];
`ifdef CMP_SERIAL_SIGNED_EN
    da = (sgn_q && last) ? da ^ MSB : da;
    db = (sgn_q && last) ? db ^ MSB : db;
`endif
  end
  cmp_digit #(.DIGIT(DIGIT), .IMPL_TYPE(IMPL_TYPE)) u_digit (
    .dA(da), .dB(db), .lt_in(lt_q), .eq_in(eq_q), .lt_out(lt_nx), .eq_out(eq_nx)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
`ifdef CMP_SERIAL_SIGNED_EN
    sgn_d   = sgn_q;
`endif
    if (state_q == RUN) begin
      lt_d    = lt_nx;
      eq_d    = eq_nx;
      idx_d   = idx_q + 1'b1;
      state_d = last ? DONE : RUN;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
    if (accept) begin
      state_d = RUN;
      mode_d  = cmp_mode_e'(mode);
      a_d     = A;
      b_d     = B;
      idx_d   = '0;
      lt_d    = 1'b0;
      eq_d    = 1'b1;
`ifdef CMP_SERIAL_SIGNED_EN
      sgn_d   = is_signed;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= CMP_LT;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b1;
`ifdef CMP_SERIAL_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
`ifdef CMP_SERIAL_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end
  assign y_sel = mode_q == CMP_LT ? lt_q :
                 mode_q == CMP_LE ? (lt_q | eq_q) :
                 mode_q == CMP_GT ? ~(lt_q | eq_q) : ~lt_q;
  assign out_valid = state_q == DONE;
  assign Y         = out_valid & y_sel;
  assign EQ        = out_valid & eq_q;
endmodule

// File: tb/tb_cmp_uint_serial.sv
// tb_cmp_uint_serial: table vectors, corner sequences and a random sweep over three DIGIT configurations, checked by a scoreboard
module tb_cmp_uint_serial;
  localparam int W  = 32;
  localparam int NI = 3;
  typedef struct { logic y; logic eq; int acc; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] m; logic y; logic eq; } vec_t;
  logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, sgn = 0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic [1:0]    op_m = '0;
  logic [NI-1:0] rdy, ov, yv, eqv, seen = '0;
  exp_t          sb[NI][$];
  vec_t          tab[12];
  int            total = 0, bad = 0, cyc = 0;
  logic          last_y = 0, last_eq = 0;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    cmp_uint_serial #(
      .WIDTH(W), .DIGIT(g == 0 ? 4 : g == 1 ? 1 : 32), .IMPL_TYPE(g == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[g]),
      .A(op_a), .B(op_b), .mode(op_m),
`ifdef CMP_SERIAL_SIGNED_EN
      .is_signed(sgn),
`endif
      .out_valid(ov[g]), .out_ready(out_ready), .Y(yv[g]), .EQ(eqv[g])
    );
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int lat_of(int k);
    return k == 0 ? 8 : k == 1 ? 32 : 1;
  endfunction
  function automatic logic [1:0] model(logic [W-1:0] x, logic [W-1:0] z, logic [1:0] m, logic s);
    logic lt, e;
    x  = s ? x ^ 32'h8000_0000 : x;
    z  = s ? z ^ 32'h8000_0000 : z;
    lt = x < z;
    e  = x == z;
    return {m == 2'd0 ? lt : m == 2'd1 ? (lt | e) : m == 2'd2 ? ~(lt | e) : ~lt, e};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask
  task automatic monitor();
    exp_t e;
    logic [1:0] r;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (!rst_n) begin
          sb[k].delete();
          seen[k] = 0;
        end else begin
          if (!ov[k]) seen[k] = 0;
          if (ov[k] && !seen[k]) begin
            seen[k] = 1;
            chk($sformatf("pending_result%0d", k), 32'(sb[k].size()), 1);
            if (sb[k].size() != 0) chk($sformatf("latency%0d", k), cyc - sb[k][0].acc, lat_of(k));
          end
          if (ov[k] && out_ready && sb[k].size() != 0) begin
            e = sb[k].pop_front();
            chk($sformatf("y%0d", k), yv[k], e.y);
            chk($sformatf("eq%0d", k), eqv[k], e.eq);
            if (k == 0) begin
              last_y  = yv[0];
              last_eq = eqv[0];
            end
          end
          if (in_valid && rdy[k]) begin
            r = model(op_a, op_b, op_m, sgn);
            e = '{y: r[1], eq: r[0], acc: cyc + 1};
            sb[k].push_back(e);
          end
        end
      end
    end
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m, input bit all);
    bit ok = 0;
    @(posedge clk); #1;
    op_a = a; op_b = b; op_m = m; in_valid = 1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = all ? &rdy : rdy[0];
    end
    chk("accept_timeout", ok, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_done(input bit all);
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = all ? (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0) : sb[0].size() == 0;
    end
    chk("result_timeout", ok, 1);
  endtask
  initial begin
    bit ok;
    logic [W-1:0] ra, rb;
    int r;
    tab[0]  = '{32'd5,        32'd7,        2'd0, 1'b1, 1'b0};
    tab[1]  = '{32'hDEADBEEF, 32'hDEADBEEF, 2'd0, 1'b0, 1'b1};
    tab[2]  = '{32'hDEADBEEF, 32'hDEADBEEF, 2'd1, 1'b1, 1'b1};
    tab[3]  = '{32'hDEADBEEF, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1};
    tab[4]  = '{32'hDEADBEEF, 32'hDEADBEEF, 2'd3, 1'b1, 1'b1};
    tab[5]  = '{32'h80000000, 32'h7FFFFFFF, 2'd2, 1'b1, 1'b0};
    tab[6]  = '{32'd7,        32'd5,        2'd1, 1'b0, 1'b0};
    tab[7]  = '{32'd0,        32'hFFFFFFFF, 2'd3, 1'b0, 1'b0};
    tab[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 2'd2, 1'b1, 1'b0};
    tab[9]  = '{32'h12345678, 32'h12345679, 2'd0, 1'b1, 1'b0};
    tab[10] = '{32'h10000000, 32'h0FFFFFFF, 2'd0, 1'b0, 1'b0};
    tab[11] = '{32'd0,        32'd0,        2'd2, 1'b0, 1'b1};
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", rdy, 3'b111);
    chk("rst_out_valid", ov, 3'b000);
    chk("rst_y", yv, 3'b000);
    chk("rst_eq", eqv, 3'b000);
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      send(tab[i].a, tab[i].b, tab[i].m, 0);
      wait_done(0);
      chk($sformatf("tab%0d_y", i), last_y, tab[i].y);
      chk($sformatf("tab%0d_eq", i), last_eq, tab[i].eq);
    end
`ifdef CMP_SERIAL_SIGNED_EN
    sgn = 1;
    send(32'h80000000, 32'h7FFFFFFF, 2'd2, 0);
    wait_done(0);
    chk("signed_gt_y", last_y, 0);
    @(posedge clk); #1;
    sgn = 0;
`endif
    @(posedge clk); #1;
    out_ready = 0;
    send(32'd5, 32'd7, 2'd0, 0);
    ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = ov[0];
    end
    chk("hold_rise", ok, 1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", ov[0], 1);
      chk("hold_y", yv[0], 1);
      chk("hold_eq", eqv[0], 0);
      chk("hold_in_ready", rdy[0], 0);
    end
    @(posedge clk); #1;
    op_a = 32'd3; op_b = 32'd9; op_m = 2'd2; in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("b2b_in_ready", rdy[0], 1);
    @(posedge clk); #1;
    in_valid = 0;
    wait_done(0);
    chk("b2b_y", last_y, 0);
    chk("b2b_eq", last_eq, 0);
    send(32'd1, 32'd2, 2'd0, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("mid_rst_in_ready", rdy, 3'b111);
    chk("mid_rst_out_valid", ov, 3'b000);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (40) begin
      @(negedge clk);
      chk("no_out_after_rst", ov, 3'b000);
    end
    send(32'h20, 32'h10, 2'd3, 0);
    wait_done(0);
    chk("post_rst_y", last_y, 1);
    chk("post_rst_eq", last_eq, 0);
    wait_done(1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      r  = $urandom_range(0, 3);
      rb = r == 0 ? ra : r == 1 ? ra ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
      send(ra, rb, 2'($urandom_range(0, 3)), 1);
      wait_done(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
